// File: rtl/shift_seq_ctrl_if.sv
// Command handshake plus register-side control/feedback signals for shift_seq_ctrl.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_rotate;
  logic             cmd_fill;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q_in;
  logic [1:0]       sel;
  logic             serial_left_out;
  logic             serial_right_out;
  logic [WIDTH-1:0] parallel_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_rotate, cmd_fill, cmd_data, q_in,
    input  cmd_ready, sel, serial_left_out, serial_right_out, parallel_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_rotate, cmd_fill, cmd_data, q_in,
    output cmd_ready, sel, serial_left_out, serial_right_out, parallel_out, busy, done
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register: turns load/shift/rotate commands into
// one register operation per ACTIVE cycle and pulses done when the command completes.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic            clk,
  input logic            reset,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [1:0]       sel_r, sel_nxt;
  logic [WIDTH-1:0] par_r, par_nxt;
  logic             done_r, done_nxt;
  logic             accept;

  // Latched command fields; only consulted while ACTIVE, so they need no reset.
  logic [1:0]       op_r;
  logic             rotate_r;
  logic             fill_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      sel_r     <= OP_NOP;
      par_r     <= '0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      sel_r     <= sel_nxt;
      par_r     <= par_nxt;
      done_r    <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r     <= bus.cmd_op;
      rotate_r <= bus.cmd_rotate;
      fill_r   <= bus.cmd_fill;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    sel_nxt       = OP_NOP;
    par_nxt       = '0;
    done_nxt      = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          case (bus.cmd_op)
            OP_NOP: done_nxt = 1'b1;
            OP_LOAD: begin
              state_nxt     = ACTIVE;
              remaining_nxt = CNT_W'(1);
              sel_nxt       = OP_LOAD;
              par_nxt       = bus.cmd_data;
            end
            default: begin
              if (bus.cmd_count == '0) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt     = ACTIVE;
                remaining_nxt = bus.cmd_count;
                sel_nxt       = bus.cmd_op;
              end
            end
          endcase
        end
      end
      ACTIVE: begin
        remaining_nxt = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          sel_nxt = sel_r;
          par_nxt = par_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill bits follow the live register contents so rotation feeds back the bit shifted out.
  always_comb begin
    bus.serial_left_out  = 1'b0;
    bus.serial_right_out = 1'b0;
    if (state == ACTIVE) begin
      if (op_r == OP_SHR)
        bus.serial_left_out = rotate_r ? bus.q_in[0] : fill_r;
      else if (op_r == OP_SHL)
        bus.serial_right_out = rotate_r ? bus.q_in[WIDTH-1] : fill_r;
    end
  end

  assign bus.cmd_ready    = (state == IDLE);
  assign bus.busy         = (state == ACTIVE);
  assign bus.sel          = sel_r;
  assign bus.parallel_out = par_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl driving a behavioural 4-bit universal shift register.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Downstream register model
  logic [WIDTH-1:0] q = '0;
  always @(posedge clk) begin
    case (bus.sel)
      2'b01: q <= {bus.serial_left_out, q[WIDTH-1:1]};
      2'b10: q <= {q[WIDTH-2:0], bus.serial_right_out};
      2'b11: q <= bus.parallel_out;
      default: q <= q;
    endcase
  end
  assign bus.q_in = q;

  typedef struct packed {
    logic [1:0]       sel;
    logic             sl;
    logic             sr;
    logic [WIDTH-1:0] par;
    logic             busy;
    logic             rdy;
    logic             done;
    logic [WIDTH-1:0] q;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic push_ev(input logic [1:0] sel, input logic sl, input logic sr,
                         input logic [3:0] par, input logic dn, input logic [3:0] qv);
    ev_t e;
    e.sel  = sel;
    e.sl   = sl;
    e.sr   = sr;
    e.par  = par;
    e.busy = (sel != 2'b00);
    e.rdy  = (sel == 2'b00);
    e.done = dn;
    e.q    = qv;
    exp_q.push_back(e);
  endtask

  // Monitor: every step cycle or done cycle must match the next expected event
  always @(negedge clk) begin
    if (!reset) begin
      ev_t act;
      act = '{bus.sel, bus.serial_left_out, bus.serial_right_out, bus.parallel_out,
              bus.busy, bus.cmd_ready, bus.done, q};
      total++;
      if (bus.done && bus.busy) begin
        bad++;
        $display("FAIL done_busy_overlap: got done=1 busy=1, need not both high");
      end
      if (bus.sel != 2'b00 || bus.done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got %h, need no activity", act);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL event: got sel=%b sl=%b sr=%b par=%b busy=%b rdy=%b done=%b q=%b, need sel=%b sl=%b sr=%b par=%b busy=%b rdy=%b done=%b q=%b",
                     act.sel, act.sl, act.sr, act.par, act.busy, act.rdy, act.done, act.q,
                     e.sel, e.sl, e.sr, e.par, e.busy, e.rdy, e.done, e.q);
          end
        end
      end else begin
        total++;
        if ({bus.serial_left_out, bus.serial_right_out, bus.parallel_out, bus.busy} !== '0) begin
          bad++;
          $display("FAIL idle_outputs: got sl=%b sr=%b par=%b busy=%b, need all 0",
                   bus.serial_left_out, bus.serial_right_out, bus.parallel_out, bus.busy);
        end
      end
    end
  end

  // Called at a negedge; presents the command when ready and returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input int cnt, input logic rot,
                       input logic fill, input logic [3:0] data);
    int n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got cmd_ready=0, need 1");
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_count  = CNT_W'(cnt);
    bus.cmd_rotate = rot;
    bus.cmd_fill   = fill;
    bus.cmd_data   = data;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_count  = '0;
    bus.cmd_rotate = 1'b0;
    bus.cmd_fill   = 1'b0;
    bus.cmd_data   = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=0, need 1");
    end
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if ({bus.sel, bus.serial_left_out, bus.serial_right_out, bus.parallel_out,
         bus.busy, bus.done, bus.cmd_ready} !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s: got sel=%b sl=%b sr=%b par=%b busy=%b done=%b rdy=%b, need 00 0 0 0000 0 0 1",
               tag, bus.sel, bus.serial_left_out, bus.serial_right_out, bus.parallel_out,
               bus.busy, bus.done, bus.cmd_ready);
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_count  = '0;
    bus.cmd_rotate = 1'b0;
    bus.cmd_fill   = 1'b0;
    bus.cmd_data   = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_state");
    reset = 1'b0;

    // Load 1011
    push_ev(2'b11, 0, 0, 4'b1011, 0, 4'b0000);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b1011);
    issue(2'b11, 0, 0, 0, 4'b1011);
    wait_done();

    // Shift right x2, fill 1
    push_ev(2'b01, 1, 0, 4'b0000, 0, 4'b1011);
    push_ev(2'b01, 1, 0, 4'b0000, 0, 4'b1101);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b1110);
    issue(2'b01, 2, 0, 1, 4'b0000);
    wait_done();

    // Reload 1011, then rotate left x3
    push_ev(2'b11, 0, 0, 4'b1011, 0, 4'b1110);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b1011);
    issue(2'b11, 0, 0, 0, 4'b1011);
    wait_done();
    push_ev(2'b10, 0, 1, 4'b0000, 0, 4'b1011);
    push_ev(2'b10, 0, 0, 4'b0000, 0, 4'b0111);
    push_ev(2'b10, 0, 1, 4'b0000, 0, 4'b1110);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b1101);
    issue(2'b10, 3, 1, 0, 4'b0000);
    wait_done();

    // Zero-count shift, then NOP with a nonzero count field
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b1101);
    issue(2'b01, 0, 0, 1, 4'b0000);
    wait_done();
    @(negedge clk);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b1101);
    issue(2'b00, 5, 1, 1, 4'b1111);
    wait_done();
    @(negedge clk);

    // Shift right x5 fill 0, reset during step 2
    push_ev(2'b01, 0, 0, 4'b0000, 0, 4'b1101);
    push_ev(2'b01, 0, 0, 4'b0000, 0, 4'b0110);
    issue(2'b01, 5, 0, 0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("mid_cmd_reset");
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_before_reset: got %0d events left, need 0", exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset_held");
    reset = 1'b0;

    // Load 0101 after reset release
    push_ev(2'b11, 0, 0, 4'b0101, 0, 4'b0110);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b0101);
    issue(2'b11, 0, 0, 0, 4'b0101);
    wait_done();

    // Back-to-back: load 0001, rotate right x4 accepted on the done cycle
    push_ev(2'b11, 0, 0, 4'b0001, 0, 4'b0101);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b0001);
    issue(2'b11, 0, 0, 0, 4'b0001);
    wait_done();
    push_ev(2'b01, 1, 0, 4'b0000, 0, 4'b0001);
    push_ev(2'b01, 0, 0, 4'b0000, 0, 4'b1000);
    push_ev(2'b01, 0, 0, 4'b0000, 0, 4'b0100);
    push_ev(2'b01, 0, 0, 4'b0000, 0, 4'b0010);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b0001);
    issue(2'b01, 4, 1, 0, 4'b0000);
    wait_done();

    // Fill-shift left x5 (beyond width) with fill 0
    push_ev(2'b10, 0, 0, 4'b0000, 0, 4'b0001);
    push_ev(2'b10, 0, 0, 4'b0000, 0, 4'b0010);
    push_ev(2'b10, 0, 0, 4'b0000, 0, 4'b0100);
    push_ev(2'b10, 0, 0, 4'b0000, 0, 4'b1000);
    push_ev(2'b10, 0, 0, 4'b0000, 0, 4'b0000);
    push_ev(2'b00, 0, 0, 4'b0000, 1, 4'b0000);
    issue(2'b10, 5, 0, 0, 4'b0000);
    wait_done();

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d unconsumed, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer that sits directly upstream of the 4-bit universal shift register. It accepts load, shift and rotate commands over a valid/ready handshake. It drives the register's mode select, serial fill bits and parallel load word cycle by cycle, and signals completion with a one-cycle done pulse. The register's parallel output is fed back in so the sequencer can implement rotation.

Parameters:
WIDTH, 4, width of the controlled shift register and of the data paths
CNT_W, 3, width of the shift-count field (max 2^CNT_W-1 shifts per command)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  2  00 NOP, 01 shift right (toward LSB, MSB filled), 10 shift left (toward MSB, LSB filled), 11 load
cmd_count  input  CNT_W  number of shift steps (ignored for NOP/load)
cmd_rotate  input  1  1: fill bit is the bit shifted out (rotate); 0: fill with cmd_fill
cmd_fill  input  1  constant fill bit when cmd_rotate=0
cmd_data  input  WIDTH  load word for op 11
q_in  input  WIDTH  current register contents (feedback)
sel  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
serial_left_out  output  1  MSB fill bit for shift right
serial_right_out  output  1  LSB fill bit for shift left
parallel_out  output  WIDTH  load word presented to register
busy  output  1  command in progress (state ACTIVE)
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any time, including mid-command): state=IDLE; sel=00; serial_left_out=0; serial_right_out=0; parallel_out=0; busy=0; done=0; cmd_ready=1; remaining count=0.
- States: IDLE, ACTIVE. cmd_ready=(state==IDLE); busy=(state==ACTIVE).
- Accept: rising edge with IDLE && cmd_valid. Latch op, count, rotate, fill and data. Command inputs are ignored at all other times.
- Transitions from accept:
  - NOP, or shift with count=0: stay IDLE; done=1 for the next cycle; sel stays 00 throughout.
  - load: go to ACTIVE with remaining=1.
  - shift with count=N>0: go to ACTIVE with remaining=N.
- ACTIVE: sel = latched op (01/10/11), registered, so the downstream register executes exactly one operation per ACTIVE cycle. Each edge decrements remaining. On the edge where remaining==1: go to IDLE, sel<=00, done<=1.
- Step counts: shift by N gives exactly N consecutive cycles of sel=01/10, starting the cycle after accept. Done is high in the cycle after the last step, together with cmd_ready=1. Load gives exactly one sel=11 cycle.
- Fill bits are combinational from state, op and q_in:
  - shift right: serial_left_out = rotate ? q_in[0] : fill.
  - shift left: serial_right_out = rotate ? q_in[WIDTH-1] : fill.
  - The unused fill output, and both fill outputs outside ACTIVE, are 0.
- parallel_out: registered. Equals latched cmd_data while a load is ACTIVE; 0 otherwise.
- Back-to-back: a command may be accepted in the same cycle done=1. No idle bubble beyond that cycle.
- Counts above WIDTH are legal. Rotate by WIDTH restores the original value; fill-shift by >=WIDTH yields all fill bits.
- done is never high while busy=1. done is never high for more than 1 cycle per command.

Test Plan:
- Load cmd_data=4'b1011 -> exactly one cycle sel=11 with parallel_out=1011; then done=1 and q=1011.
- From q=1011: shift right, count=2, fill=1, rotate=0 -> two cycles sel=01 with serial_left_out=1; q=1101 then 1110; done on the following cycle.
- From q=1011: shift left, count=3, rotate=1 -> q sequence 0111, 1110, 1101; serial_right_out tracks q_in[3] each step.
- Shift with count=0, and NOP -> sel stays 00, q unchanged, done pulse exactly 1 cycle after accept, busy never high.
- Reset asserted during step 2 of a 5-step shift -> immediately sel=00, busy=0, done=0, cmd_ready=1. A new load issued after reset release completes normally.
- Back-to-back: load 4'b0001 then, on its done cycle, rotate right count=4 -> cmd_ready=1 on the done cycle; 4 steps; final q=0001.
